// File: rtl/regfile_mp.sv
// Multi-port register file with dual write ports and per-register pending scoreboard.
// Writes commit on posedge and reads register on negedge, so a write is visible on RD half a cycle later.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                      CLK,
   input  logic                      RSTn,
   input  logic [NREAD*ADDR_W-1:0]   RA,
   output logic [NREAD*DATA_W-1:0]   RD,
   output logic [NREAD-1:0]          RRDY,
   input  logic                      WE0,
   input  logic [ADDR_W-1:0]         WA0,
   input  logic [DATA_W-1:0]         WD0,
   input  logic                      WE1,
   input  logic [ADDR_W-1:0]         WA1,
   input  logic [DATA_W-1:0]         WD1,
   input  logic                      ISSUE,
   input  logic [ADDR_W-1:0]         ISSUE_A
);

   localparam int              DEPTH  = 1 << ADDR_W;
   localparam bit              ZR     = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] ZERO_A = '0;

   logic [DATA_W-1:0]       regs_q [DEPTH];
   logic [DEPTH-1:0]        pend_q, pend_d;
   logic [NREAD*DATA_W-1:0] rd_q, rd_d;
   logic [NREAD-1:0]        rrdy_q, rrdy_d;
   logic                    we0_ok, we1_ok, iss_ok;

   // Register 0 is invisible to every write-side action when hardwired to zero.
   assign we0_ok = WE0   && !(ZR && (WA0 == ZERO_A));
   assign we1_ok = WE1   && !(ZR && (WA1 == ZERO_A));
   assign iss_ok = ISSUE && !(ZR && (ISSUE_A == ZERO_A));

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (we0_ok && !(we1_ok && (WA1 == WA0))) begin
            regs_q[WA0] <= WD0;
         end
         if (we1_ok) begin
            regs_q[WA1] <= WD1;
         end
      end
   end

   // Issue is applied after the clears so a new producer supersedes a retiring one.
   always_comb begin
      pend_d = pend_q;
      if (we0_ok) pend_d[WA0] = 1'b0;
      if (we1_ok) pend_d[WA1] = 1'b0;
      if (iss_ok) pend_d[ISSUE_A] = 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      a      = '0;
      rd_d   = '0;
      rrdy_d = '0;
      for (int k = 0; k < NREAD; k++) begin
         a = RA[k*ADDR_W +: ADDR_W];
         if (ZR && (a == ZERO_A)) begin
            rd_d[k*DATA_W +: DATA_W] = '0;
            rrdy_d[k]                = 1'b1;
         end else begin
            rd_d[k*DATA_W +: DATA_W] = regs_q[a];
            rrdy_d[k]                = ~pend_q[a];
         end
      end
   end

   always_ff @(negedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rd_q   <= '0;
         rrdy_q <= '0;
      end else begin
         rd_q   <= rd_d;
         rrdy_q <= rrdy_d;
      end
   end

   assign RD   = rd_q;
   assign RRDY = rrdy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default config, ZERO_REG=0 config and a 64-bit/4-port/16-entry config.
module tb_regfile_mp;

   logic        CLK = 1'b0;
   logic        RSTn;
   // u0 (default) and u1 (ZERO_REG=0, one read port) share the write side
   logic [9:0]  ra0;
   logic [63:0] rd0;
   logic [1:0]  rrdy0;
   logic [4:0]  ra1;
   logic [31:0] rd1;
   logic        rrdy1;
   logic        we0, we1, issue;
   logic [4:0]  wa0, wa1, issue_a;
   logic [31:0] wd0, wd1;
   // u2: DATA_W=64, ADDR_W=4, NREAD=4, ZERO_REG=0
   logic [15:0]  ra2;
   logic [255:0] rd2;
   logic [3:0]   rrdy2;
   logic         we2, zero1;
   logic [3:0]   wa2, zero4;
   logic [63:0]  wd2, zero64;

   int checks   = 0;
   int failures = 0;

   int          exp_dut  [$];
   int          exp_port [$];
   logic [63:0] exp_dat  [$];
   logic        exp_rdy  [$];
   string       exp_tag  [$];

   always #5 CLK = ~CLK;

   regfile_mp u0 (
      .CLK(CLK), .RSTn(RSTn), .RA(ra0), .RD(rd0), .RRDY(rrdy0),
      .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
      .ISSUE(issue), .ISSUE_A(issue_a)
   );

   regfile_mp #(.NREAD(1), .ZERO_REG(0)) u1 (
      .CLK(CLK), .RSTn(RSTn), .RA(ra1), .RD(rd1), .RRDY(rrdy1),
      .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
      .ISSUE(issue), .ISSUE_A(issue_a)
   );

   regfile_mp #(.DATA_W(64), .ADDR_W(4), .NREAD(4), .ZERO_REG(0)) u2 (
      .CLK(CLK), .RSTn(RSTn), .RA(ra2), .RD(rd2), .RRDY(rrdy2),
      .WE0(we2), .WA0(wa2), .WD0(wd2), .WE1(zero1), .WA1(zero4), .WD1(zero64),
      .ISSUE(zero1), .ISSUE_A(zero4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_rd(input int dut, input int port, input logic [63:0] dat,
                            input logic rdy, input string tag);
      exp_dut.push_back(dut);
      exp_port.push_back(port);
      exp_dat.push_back(dat);
      exp_rdy.push_back(rdy);
      exp_tag.push_back(tag);
   endtask

   function automatic logic [64:0] observe(input int dut, input int port);
      case (dut)
         0:       return {rrdy0[port], 32'h0, rd0[port*32 +: 32]};
         1:       return {rrdy1, 32'h0, rd1};
         default: return {rrdy2[port], rd2[port*64 +: 64]};
      endcase
   endfunction

   task automatic drain();
      logic [64:0] o;
      string       t;
      int          d, p;
      while (exp_dat.size() > 0) begin
         d = exp_dut.pop_front();
         p = exp_port.pop_front();
         t = exp_tag.pop_front();
         o = observe(d, p);
         chk($sformatf("%s.u%0d.p%0d.rd", t, d, p), o[63:0], exp_dat.pop_front());
         chk($sformatf("%s.u%0d.p%0d.rrdy", t, d, p), {63'h0, o[64]}, {63'h0, exp_rdy.pop_front()});
      end
   endtask

   // Sample point: one unit after the negedge that updates RD.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      #1;
      drain();
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; issue = 1'b0; we2 = 1'b0;
   endtask

   function automatic logic [63:0] val64(input int i);
      return (64'h1111_1111_1111_1111 * 64'(i + 1)) ^ 64'hF0F0_0000_0000_0F0F;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      RSTn = 1'b0; idle();
      ra0 = '0; ra1 = '0; ra2 = '0;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; issue_a = '0;
      wa2 = '0; wd2 = '0; zero1 = 1'b0; zero4 = '0; zero64 = '0;

      // held in reset
      expect_rd(0, 0, 64'h0, 1'b0, "rst_hold");
      expect_rd(0, 1, 64'h0, 1'b0, "rst_hold");
      tick();
      RSTn = 1'b1;

      // write r5, then async reset mid-cycle
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra0 = {5'd5, 5'd5};
      expect_rd(0, 0, 64'hDEADBEEF, 1'b1, "r5_wr");
      tick();
      idle();
      @(posedge CLK); #2;
      RSTn = 1'b0;
      #1;
      expect_rd(0, 0, 64'h0, 1'b0, "rst_async");
      expect_rd(0, 1, 64'h0, 1'b0, "rst_async");
      drain();
      @(negedge CLK); #1;
      RSTn = 1'b1;
      expect_rd(0, 0, 64'h0, 1'b1, "r5_after_rst");
      expect_rd(0, 1, 64'h0, 1'b1, "r5_after_rst");
      tick();

      // same-cycle write and read on both ports
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; ra0 = {5'd7, 5'd7};
      expect_rd(0, 0, 64'h12345678, 1'b1, "wr_rd_same");
      expect_rd(0, 1, 64'h12345678, 1'b1, "wr_rd_same");
      tick();

      // collision: port 1 wins
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA0000;
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000BBBB; ra0 = {5'd7, 5'd3};
      expect_rd(0, 0, 64'h0000BBBB, 1'b1, "collide");
      expect_rd(0, 1, 64'h12345678, 1'b1, "collide_other");
      tick();
      wa0 = 5'd3; wd0 = 32'h11111111; wa1 = 5'd4; wd1 = 32'h22222222; ra0 = {5'd4, 5'd3};
      expect_rd(0, 0, 64'h11111111, 1'b1, "dual_wr");
      expect_rd(0, 1, 64'h22222222, 1'b1, "dual_wr");
      tick();
      idle();

      // zero register, with and without hardwiring
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; issue = 1'b1; issue_a = 5'd0;
      ra0 = {5'd0, 5'd0}; ra1 = 5'd0;
      expect_rd(0, 0, 64'h0, 1'b1, "zero_hw");
      expect_rd(0, 1, 64'h0, 1'b1, "zero_hw");
      expect_rd(1, 0, 64'hFFFFFFFF, 1'b0, "zero_soft");
      tick();
      idle();

      // pending scoreboard on r9
      issue = 1'b1; issue_a = 5'd9; ra0 = {5'd3, 5'd9};
      expect_rd(0, 0, 64'h0, 1'b0, "sb_issue");
      expect_rd(0, 1, 64'h11111111, 1'b1, "sb_other");
      tick();
      idle();
      for (int c = 2; c <= 3; c++) begin
         expect_rd(0, 0, 64'h0, 1'b0, $sformatf("sb_wait%0d", c));
         tick();
      end
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFE0009;
      expect_rd(0, 0, 64'hCAFE0009, 1'b1, "sb_wb");
      tick();
      idle();
      issue = 1'b1; issue_a = 5'd9; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0BAD0009;
      expect_rd(0, 0, 64'h0BAD0009, 1'b0, "sb_issue_wb");
      tick();
      we1 = 1'b0;
      expect_rd(0, 0, 64'h0BAD0009, 1'b0, "sb_reissue");
      tick();
      idle();
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99999999;
      expect_rd(0, 0, 64'h99999999, 1'b1, "sb_clear");
      tick();
      wa0 = 5'd31; wd0 = 32'h31313131; ra0 = {5'd31, 5'd9};
      expect_rd(0, 0, 64'h99999999, 1'b1, "nonpend_hold");
      expect_rd(0, 1, 64'h31313131, 1'b1, "r31");
      tick();
      idle();

      // wide configuration: write all entries, then concurrent reads
      for (int i = 0; i < 16; i++) begin
         we2 = 1'b1; wa2 = 4'(i); wd2 = val64(i);
         ra2 = {4{4'(i)}};
         for (int k = 0; k < 4; k++) begin
            expect_rd(2, k, val64(i), 1'b1, $sformatf("w64_r%0d", i));
         end
         tick();
      end
      idle();
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 4; k++) begin
            ra2[k*4 +: 4] = 4'(15 - (g * 4 + k));
            expect_rd(2, k, val64(15 - (g * 4 + k)), 1'b1, $sformatf("sweep_g%0d", g));
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-status scoreboard for the pipelined CPU's decode stage. Generalises the single-write/two-read file with:
- configurable data width, depth and read-port count;
- a second write port;
- an optional hardwired-zero register;
- asynchronous clear;
- per-register pending bits, so decode can detect operands whose producer has not yet written back.

Writes happen in the first half of the cycle and reads in the second half, so writeback-to-decode needs no external forwarding.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending.

Ports:
- CLK  in  1  clock; writes on rising edge, reads on falling edge.
- RSTn  in  1  reset, asynchronous, active-low.
- RA  in  NREAD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- RD  out  NREAD*DATA_W  read data, registered; port k = bits [k*DATA_W +: DATA_W].
- RRDY  out  NREAD  1 = register at RA[k] was not pending when sampled.
- WE0  in  1  write enable, port 0 (normal writeback).
- WA0  in  ADDR_W  write address, port 0.
- WD0  in  DATA_W  write data, port 0.
- WE1  in  1  write enable, port 1 (late / long-latency writeback).
- WA1  in  ADDR_W  write address, port 1.
- WD1  in  DATA_W  write data, port 1.
- ISSUE  in  1  marks register ISSUE_A pending (instruction with destination issued).
- ISSUE_A  in  ADDR_W  destination being issued.

## Operation
Register array, DEPTH x DATA_W; PEND vector, DEPTH bits.

Reset:
- RSTn low asynchronously clears all registers, PEND, RD and RRDY to 0.
- All these outputs read 0 while RSTn is low.

Write, on posedge CLK:
- WE0 writes WD0 to WA0; WE1 writes WD1 to WA1.
- WE0 and WE1 to the same address: port 1 wins; WD0 is discarded.
- A write to address 0 with ZERO_REG=1 is ignored.

Pending, on posedge CLK:
- A write on either port clears PEND[WA].
- ISSUE sets PEND[ISSUE_A].
- ISSUE and a write to the same address in the same edge: set wins, so PEND=1 (a new producer supersedes the retiring one).
- ISSUE_A=0 with ZERO_REG=1 has no effect.

Read, on negedge CLK, for each port k independently:
- RD[k] <= REG[RA[k]].
- RRDY[k] <= ~PEND[RA[k]].
- With ZERO_REG=1 and RA[k]=0: RD[k] <= 0 and RRDY[k] <= 1.
- Any two ports may address the same register.

Reads see the state after the preceding posedge. A value written at posedge t appears on RD at negedge t, i.e. same cycle.

## Timing
Write:
- Latency 0.5 cycle from posedge (write committed) to negedge (RD valid).
- RD/RRDY stay stable from negedge to the next negedge; consumers sample them at posedge.

Reset:
- Asserting RSTn mid-cycle overrides any pending edge.
- First write is accepted at the first posedge after RSTn rises.
- First RD update occurs at the first negedge after RSTn rises.

Boundaries:
- Address DEPTH-1 behaves like any other register.
- No address wrap occurs; addresses are exactly ADDR_W bits.
- Multiple ISSUE to the same pending register leaves it pending.
- A write to a non-pending register leaves PEND at 0.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse RSTn low mid-cycle -> RD and RRDY go 0 immediately; reading r5 after release -> RD=0, RRDY=1.
- Same-cycle write/read: WE0, WA0=7, WD0=0x12345678, RA0=7 -> RD0=0x12345678 at that cycle's negedge. Also RA1=7 -> RD1 identical.
- Write collision: WE0 (r3, 0xAAAA0000) and WE1 (r3, 0x0000BBBB) on the same edge -> r3 reads 0x0000BBBB. Separate addresses r3/r4 on the same edge -> both written.
- Zero register, ZERO_REG=1: WE1, WA1=0, WD1=0xFFFFFFFF and ISSUE_A=0 -> RA=0 gives RD=0, RRDY=1. Repeat with ZERO_REG=0 -> RD=0xFFFFFFFF, RRDY=0.
- Scoreboard, register 9:
  - ISSUE r9 at cycle 1 -> RRDY=0 from cycle 1 negedge.
  - WE0 r9 at cycle 4 -> RRDY=1 and new data at cycle 4 negedge.
  - ISSUE r9 coinciding with WE1 r9 -> RRDY stays 0, data updated.
- Parameter sweep: DATA_W=64, ADDR_W=4, NREAD=4 -> write 16 distinct 64-bit values to r0..r15, read back all four ports concurrently; including r15 -> all match.
